// File: rtl/s6bit_accum_seq_pkg.sv
// s6bit_accum_seq_pkg: shared widths, signed limits and sequencer states
package s6bit_accum_seq_pkg;
    localparam int S6_W = 6;
    localparam logic [S6_W-1:0] S6_MAX = 6'b011111;
    localparam logic [S6_W-1:0] S6_MIN = 6'b100000;
    localparam int CNT_W = 4;
    typedef enum logic {RUN, HOLD} state_t;
endpackage

// File: rtl/s6bit_accum_seq_if.sv
// s6bit_accum_seq_if: operand stream in, packet result out
interface s6bit_accum_seq_if;
    import s6bit_accum_seq_pkg::*;
    logic [S6_W-1:0] in_data;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic [S6_W-1:0] out_sum;
    logic out_ovf;
    logic [CNT_W-1:0] out_count;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input in_ready, out_sum, out_ovf, out_count, out_valid
    );
    modport slave (
        input in_data, in_valid, in_last, out_ready,
        output in_ready, out_sum, out_ovf, out_count, out_valid
    );
endinterface

// File: rtl/s6bit_accum_seq_sat.sv
// s6bit_sat: clamps a signed sum to the rail matching the operand sign on overflow
module s6bit_sat
    import s6bit_accum_seq_pkg::*;
(
    input  logic [S6_W-1:0] sum,
    input  logic ovf,
    input  logic a_sign,
    input  logic enable,
    output logic [S6_W-1:0] y
);
    assign y = (ovf && enable) ? (a_sign ? S6_MIN : S6_MAX) : sum;
endmodule

// File: rtl/s6bit_accum_seq.sv
// s6bit_accum_seq: packetised signed accumulator around an external 6-bit adder
module s6bit_accum_seq
    import s6bit_accum_seq_pkg::*;
#(
    parameter bit SATURATE = 1'b0,
    parameter int MAX_TERMS = 15
) (
    input  logic clk,
    input  logic rst,
    s6bit_accum_seq_if.slave bus,
    output logic [S6_W-1:0] add_a,
    output logic [S6_W-1:0] add_b,
    input  logic [S6_W-1:0] add_sum,
    input  logic add_ovf
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    state_t state, state_nx;
    logic [S6_W-1:0] acc, acc_nx, sat_val;
    logic sticky, sticky_nx;
    logic [CNT_W-1:0] count, count_nx;

    assign add_a = acc;
    assign add_b = bus.in_data;
    assign bus.in_ready = state == RUN;
    assign bus.out_valid = state == HOLD;
    assign bus.out_sum = acc;
    assign bus.out_ovf = sticky;
    assign bus.out_count = count;

    s6bit_sat u_sat (
        .sum(add_sum),
        .ovf(add_ovf),
        .a_sign(add_a[S6_W-1]),
        .enable(SATURATE),
        .y(sat_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            acc <= '0;
            sticky <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nx;
            acc <= acc_nx;
            sticky <= sticky_nx;
            count <= count_nx;
        end
    end

    // HOLD ignores the input stream entirely; RUN ignores out_ready
    always_comb begin
        state_nx = state;
        acc_nx = acc;
        sticky_nx = sticky;
        count_nx = count;
        if (state == RUN) begin
            if (bus.in_valid) begin
                acc_nx = sat_val;
                sticky_nx = sticky | add_ovf;
                count_nx = count + 1'b1;
                state_nx = (bus.in_last || count_nx == MAX_CNT) ? HOLD : RUN;
            end
        end else if (bus.out_ready) begin
            acc_nx = '0;
            sticky_nx = 1'b0;
            count_nx = '0;
            state_nx = RUN;
        end
    end
endmodule
